// File: rtl/mmio_tx_fifo_if.sv
// Bundle between the EX stage, the MMIO transmit FIFO and the downstream transmitter.
// The slave modport is the FIFO side; master is the EX/transmitter side.
interface mmio_tx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
);
   logic                      start_i;
   logic                      mem_req_i;
   logic                      mem_we_i;
   logic [31:0]               mem_addr_i;
   logic [31:0]               mem_wdata_i;
   logic                      stall_o;
   logic                      ready_o;
   logic                      busy_o;
   logic                      done_o;
   logic [$clog2(DEPTH):0]    count_o;
   logic                      tx_valid_o;
   logic [DATA_W-1:0]         tx_data_o;
   logic                      tx_ready_i;

   modport slave (
      input  start_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, tx_ready_i,
      output stall_o, ready_o, busy_o, done_o, count_o, tx_valid_o, tx_data_o
   );

   modport master (
      output start_i, mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, tx_ready_i,
      input  stall_o, ready_o, busy_o, done_o, count_o, tx_valid_o, tx_data_o
   );
endinterface

// File: rtl/mmio_tx_fifo.sv
// Snoops EX-stage writes to an MMIO data address, buffers them in a FIFO and
// drains them over a valid/ready link; writing bit 0 of the control address flushes storage.
module mmio_tx_fifo #(
   parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
   parameter int          DATA_W    = 8,
   parameter int          DEPTH     = 8
) (
   input  logic             clk,
   input  logic             rst,
   mmio_tx_fifo_if.slave    bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, SEND} state_t;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [DATA_W-1:0] r_tx_data;
   logic              r_busy_prev;
   state_t            r_state;
   state_t            w_state_next;

   logic w_hit;
   logic w_push_hit;
   logic w_ctl_hit;
   logic w_full;
   logic w_push;
   logic w_flush;
   logic w_avail;
   logic w_pop;
   logic w_busy;
   logic w_unused_wdata;

   assign w_hit      = bus.start_i & bus.mem_req_i & bus.mem_we_i;
   assign w_push_hit = w_hit & (bus.mem_addr_i == ADDR_BASE);
   assign w_ctl_hit  = w_hit & (bus.mem_addr_i == (ADDR_BASE + 32'd4));
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_push     = w_push_hit & ~w_full;
   assign w_flush    = w_ctl_hit & bus.mem_wdata_i[0];
   // A flush empties storage on this edge, so the head must not be popped alongside it.
   assign w_avail    = (r_count != '0) & ~w_flush;
   assign w_busy     = (r_count != '0) | (r_state == SEND);
   assign w_unused_wdata = &{1'b0, bus.mem_wdata_i};

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_avail) begin
               w_pop        = 1'b1;
               w_state_next = SEND;
            end
         end
         SEND: begin
            if (bus.tx_ready_i) begin
               if (w_avail) begin
                  w_pop = 1'b1;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.mem_wdata_i[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_tx_data   <= '0;
         r_busy_prev <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_busy_prev <= w_busy;
         if (w_pop) begin
            r_tx_data <= r_mem[r_rd_ptr];
         end
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   assign bus.stall_o    = w_push_hit & w_full;
   assign bus.ready_o    = ~w_full;
   assign bus.busy_o     = w_busy;
   assign bus.done_o     = r_busy_prev & ~w_busy;
   assign bus.count_o    = r_count;
   assign bus.tx_valid_o = (r_state == SEND);
   assign bus.tx_data_o  = r_tx_data;
endmodule

// File: tb/tb_mmio_tx_fifo.sv
// Directed bench for mmio_tx_fifo: the driver queues expected bytes, a negedge
// monitor pops them on every completed handshake.
module tb_mmio_tx_fifo;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam logic [31:0] A_DATA = 32'h3000_0000;
   localparam logic [31:0] A_CTL  = 32'h3000_0004;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   done_cnt;
   int   max_cnt;
   logic [7:0] exp_q[$];

   mmio_tx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();

   mmio_tx_fifo #(.ADDR_BASE(A_DATA), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a handshake completes at the next rising edge.
   always @(negedge clk) begin
      if (bus.done_o === 1'b1) done_cnt++;
      if (int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
      if (!rst && bus.tx_valid_o && bus.tx_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got=%h required=none", bus.tx_data_o);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.tx_data_o !== e) begin
               errors++;
               $display("FAIL tx_data: got=%h required=%h", bus.tx_data_o, e);
            end else begin
               $display("tx byte %h ok", bus.tx_data_o);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic st,
                     input logic we, input logic exp_stall, input logic exp_push);
      bus.start_i     = st;
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_addr_i  = addr;
      bus.mem_wdata_i = data;
      #1;
      chk("stall", {31'd0, bus.stall_o}, {31'd0, exp_stall});
      if (exp_push) exp_q.push_back(data[7:0]);
      $display("write addr=%h data=%h start=%0d we=%0d stall=%0d", addr, data, st, we, bus.stall_o);
      tick();
      bus.mem_req_i = 1'b0;
      bus.mem_we_i  = 1'b0;
      bus.start_i   = 1'b1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy_o) && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_drained"}, {31'd0, (exp_q.size() == 0 && !bus.busy_o)}, 32'd1);
   endtask

   initial begin
      int d0;
      checks = 0; errors = 0; done_cnt = 0; max_cnt = 0;
      rst = 1'b1;
      bus.start_i = 1'b1; bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
      bus.mem_addr_i = '0; bus.mem_wdata_i = '0; bus.tx_ready_i = 1'b0;
      tick(); tick();
      chk("rst_ready", {31'd0, bus.ready_o}, 32'd1);
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("rst_done", {31'd0, bus.done_o}, 32'd0);
      chk("rst_count", {28'd0, bus.count_o}, 32'd0);
      chk("rst_valid", {31'd0, bus.tx_valid_o}, 32'd0);
      chk("rst_data", {24'd0, bus.tx_data_o}, 32'd0);
      chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
      rst = 1'b0;
      tick();

      // Single push, latency and done pulse
      bus.tx_ready_i = 1'b1;
      d0 = done_cnt;
      wr(A_DATA, 32'h0000_0041, 1, 1, 0, 1);
      chk("single_count1", {28'd0, bus.count_o}, 32'd1);
      chk("single_valid_early", {31'd0, bus.tx_valid_o}, 32'd0);
      tick();
      chk("single_valid", {31'd0, bus.tx_valid_o}, 32'd1);
      chk("single_data", {24'd0, bus.tx_data_o}, 32'h41);
      chk("single_count0", {28'd0, bus.count_o}, 32'd0);
      tick();
      chk("single_busy0", {31'd0, bus.busy_o}, 32'd0);
      chk("single_done1", {31'd0, bus.done_o}, 32'd1);
      tick();
      chk("single_done0", {31'd0, bus.done_o}, 32'd0);
      chk("single_done_cnt", done_cnt - d0, 32'd1);

      // Fill and stall with the output stage blocked
      bus.tx_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) wr(A_DATA, 32'h10 + i, 1, 1, 0, 1);
      chk("fill_count8", {28'd0, bus.count_o}, 32'd8);
      chk("fill_ready0", {31'd0, bus.ready_o}, 32'd0);
      chk("fill_head", {24'd0, bus.tx_data_o}, 32'h10);
      wr(A_DATA, 32'h19, 1, 1, 1, 0);
      chk("fill_count_held", {28'd0, bus.count_o}, 32'd8);
      bus.tx_ready_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chk("fill_no_gap", {31'd0, bus.tx_valid_o}, 32'd1);
         tick();
      end
      chk("fill_busy0", {31'd0, bus.busy_o}, 32'd0);
      chk("fill_done1", {31'd0, bus.done_o}, 32'd1);
      drain("fill", 20);

      // Pointer wrap with tx_ready_i toggling every cycle
      max_cnt = 0;
      bus.tx_ready_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.tx_ready_i = ~bus.tx_ready_i;
         wr(A_DATA, 32'h80 + i, 1, 1, 0, 1);
         bus.tx_ready_i = ~bus.tx_ready_i;
         tick();
      end
      bus.tx_ready_i = 1'b1;
      drain("wrap", 60);
      chk("wrap_max_le8", {31'd0, (max_cnt <= DEPTH)}, 32'd1);

      // Flush keeps the in-flight byte only
      bus.tx_ready_i = 1'b0;
      wr(A_DATA, 32'h01, 1, 1, 0, 1);
      wr(A_DATA, 32'h02, 1, 1, 0, 1);
      wr(A_DATA, 32'h03, 1, 1, 0, 1);
      chk("flush_pre_count", {28'd0, bus.count_o}, 32'd2);
      wr(A_CTL, 32'h1, 1, 1, 0, 0);
      exp_q.delete();
      exp_q.push_back(8'h01);
      chk("flush_count0", {28'd0, bus.count_o}, 32'd0);
      chk("flush_valid", {31'd0, bus.tx_valid_o}, 32'd1);
      chk("flush_data", {24'd0, bus.tx_data_o}, 32'h01);
      bus.tx_ready_i = 1'b1;
      drain("flush", 10);
      tick(); tick();
      chk("flush_idle", {31'd0, bus.tx_valid_o}, 32'd0);

      // Filters: nothing reaches storage
      bus.tx_ready_i = 1'b0;
      wr(A_DATA, 32'h55, 0, 1, 0, 0);
      wr(A_DATA, 32'h56, 1, 0, 0, 0);
      wr(32'h3000_0008, 32'h57, 1, 1, 0, 0);
      wr(A_CTL, 32'h1, 0, 1, 0, 0);
      tick();
      chk("filter_count0", {28'd0, bus.count_o}, 32'd0);
      chk("filter_busy0", {31'd0, bus.busy_o}, 32'd0);

      // Reset mid-operation
      for (int i = 0; i < 6; i++) wr(A_DATA, 32'hA0 + i, 1, 1, 0, 1);
      chk("midrst_count5", {28'd0, bus.count_o}, 32'd5);
      chk("midrst_valid1", {31'd0, bus.tx_valid_o}, 32'd1);
      rst = 1'b1;
      tick();
      exp_q.delete();
      chk("midrst_ready", {31'd0, bus.ready_o}, 32'd1);
      chk("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("midrst_done", {31'd0, bus.done_o}, 32'd0);
      chk("midrst_count", {28'd0, bus.count_o}, 32'd0);
      chk("midrst_valid", {31'd0, bus.tx_valid_o}, 32'd0);
      chk("midrst_data", {24'd0, bus.tx_data_o}, 32'd0);
      rst = 1'b0;
      tick();
      bus.tx_ready_i = 1'b1;
      wr(A_DATA, 32'h5A, 1, 1, 0, 1);
      drain("post_rst", 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
